syndrome_frame_sender: RTL

SYNDROME_FRAME_SENDER -- requirements
Module: syndrome_frame_sender

---
 rtl/syndrome_frame_sender.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/syndrome_frame_sender.sv
// Purpose: serialises measurement and erasure rounds into header-prefixed byte frames; also emits a one-byte start command.
// Latency: a round is accepted in its LOAD state and its first byte is valid the next cycle, then one byte per cycle.
// Backpressure: output bytes hold stable until output_ready; meas_ready/eras_ready are raised only in the LOAD states.
module syndrome_frame_sender #(
    parameter int          GRID_WIDTH_X = 4,
    parameter int          GRID_WIDTH_Z = 1,
    parameter int          GRID_WIDTH_U = 3,
    parameter int          ERASURE_EN   = 1,
    parameter logic [7:0]  START_MSG    = 8'h01,
    parameter logic [7:0]  MEAS_HEADER  = 8'h02,
    localparam int         MW           = GRID_WIDTH_X * GRID_WIDTH_Z,
    localparam int         MB           = (MW + 7) / 8,
    localparam int         EW           = GRID_WIDTH_U * GRID_WIDTH_U - (GRID_WIDTH_U - 1),
    localparam int         EB           = (EW + 7) / 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_cmd,
    input  logic [MW-1:0]   meas_data,
    input  logic            meas_valid,
    output logic            meas_ready,
    input  logic [EW-1:0]   eras_data,
    input  logic            eras_valid,
    output logic            eras_ready,
    output logic [7:0]      output_data,
    output logic            output_valid,
    input  logic            output_ready,
    output logic            busy,
    output logic [15:0]     frame_count
);

    // Shift register is sized for the wider of the two round types.
    localparam int SB  = (MB > EB) ? MB : EB;
    localparam int SW  = SB * 8;
    localparam int BCW = $clog2(SB + 1);
    localparam int RCW = $clog2(GRID_WIDTH_U + 1);

    localparam logic [BCW-1:0] MB_LAST = BCW'(MB - 1);
    localparam logic [BCW-1:0] EB_LAST = BCW'(EB - 1);
    localparam logic [RCW-1:0] U_LAST  = RCW'(GRID_WIDTH_U - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_HDR, ST_M_LOAD, ST_M_SEND, ST_E_LOAD, ST_E_SEND
    } state_t;

    state_t          r_state;
    logic [SW-1:0]   r_shift;
    logic [BCW-1:0]  r_byte_cnt;
    logic [RCW-1:0]  r_round;
    logic [7:0]      r_out_data;
    logic            r_out_vld;
    logic            r_meas_rdy;
    logic            r_eras_rdy;
    logic            r_busy;
    logic [15:0]     r_frame_cnt;

    logic [SW-1:0]   w_meas_ext;
    logic [SW-1:0]   w_eras_ext;
    logic [SW-1:0]   w_shift_nxt;

    // Rounds are zero-extended so pad bits of the last byte go out as 0.
    assign w_meas_ext  = SW'(meas_data);
    assign w_eras_ext  = SW'(eras_data);
    assign w_shift_nxt = r_shift >> 8;

    // Frame FSM; every output is registered and set on the transition into its state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_byte_cnt  <= '0;
            r_round     <= '0;
            r_out_data  <= '0;
            r_out_vld   <= 1'b0;
            r_meas_rdy  <= 1'b0;
            r_eras_rdy  <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_cmd) begin
                        r_state    <= ST_CMD;
                        r_out_vld  <= 1'b1;
                        r_out_data <= START_MSG;
                        r_busy     <= 1'b1;
                    end else if (meas_valid) begin
                        r_state    <= ST_HDR;
                        r_out_vld  <= 1'b1;
                        r_out_data <= MEAS_HEADER;
                        r_busy     <= 1'b1;
                    end
                end
                ST_CMD: begin
                    if (output_ready) begin
                        r_state    <= ST_IDLE;
                        r_out_vld  <= 1'b0;
                        r_out_data <= '0;
                        r_busy     <= 1'b0;
                    end
                end
                ST_HDR: begin
                    if (output_ready) begin
                        r_state    <= ST_M_LOAD;
                        r_out_vld  <= 1'b0;
                        r_out_data <= '0;
                        r_meas_rdy <= 1'b1;
                        r_round    <= '0;
                    end
                end
                ST_M_LOAD: begin
                    if (meas_valid) begin
                        r_state    <= ST_M_SEND;
                        r_meas_rdy <= 1'b0;
                        r_shift    <= w_meas_ext;
                        r_byte_cnt <= '0;
                        r_out_vld  <= 1'b1;
                        r_out_data <= w_meas_ext[7:0];
                    end
                end
                ST_M_SEND: begin
                    if (output_ready) begin
                        r_shift <= w_shift_nxt;
                        if (r_byte_cnt == MB_LAST) begin
                            r_out_vld  <= 1'b0;
                            r_out_data <= '0;
                            if (r_round != U_LAST) begin
                                r_round    <= r_round + RCW'(1);
                                r_state    <= ST_M_LOAD;
                                r_meas_rdy <= 1'b1;
                            end else if (ERASURE_EN != 0) begin
                                r_round    <= '0;
                                r_state    <= ST_E_LOAD;
                                r_eras_rdy <= 1'b1;
                            end else begin
                                r_round     <= '0;
                                r_state     <= ST_IDLE;
                                r_busy      <= 1'b0;
                                r_frame_cnt <= r_frame_cnt + 16'd1;
                            end
                        end else begin
                            r_byte_cnt <= r_byte_cnt + BCW'(1);
                            r_out_data <= w_shift_nxt[7:0];
                        end
                    end
                end
                ST_E_LOAD: begin
                    if (eras_valid) begin
                        r_state    <= ST_E_SEND;
                        r_eras_rdy <= 1'b0;
                        r_shift    <= w_eras_ext;
                        r_byte_cnt <= '0;
                        r_out_vld  <= 1'b1;
                        r_out_data <= w_eras_ext[7:0];
                    end
                end
                ST_E_SEND: begin
                    if (output_ready) begin
                        r_shift <= w_shift_nxt;
                        if (r_byte_cnt == EB_LAST) begin
                            r_out_vld  <= 1'b0;
                            r_out_data <= '0;
                            if (r_round != U_LAST) begin
                                r_round    <= r_round + RCW'(1);
                                r_state    <= ST_E_LOAD;
                                r_eras_rdy <= 1'b1;
                            end else begin
                                r_round     <= '0;
                                r_state     <= ST_IDLE;
                                r_busy      <= 1'b0;
                                r_frame_cnt <= r_frame_cnt + 16'd1;
                            end
                        end else begin
                            r_byte_cnt <= r_byte_cnt + BCW'(1);
                            r_out_data <= w_shift_nxt[7:0];
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_out_vld  <= 1'b0;
                    r_out_data <= '0;
                    r_meas_rdy <= 1'b0;
                    r_eras_rdy <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign output_data  = r_out_data;
    assign output_valid = r_out_vld;
    assign meas_ready   = r_meas_rdy;
    assign eras_ready   = r_eras_rdy;
    assign busy         = r_busy;
    assign frame_count  = r_frame_cnt;

endmodule
